// File: rtl/picosoc_iomem_mux_if.sv
// PicoSoC iomem bus between the CPU master port and the peripheral mux.
// The master modport is the CPU side; the slave modport is the mux side.
interface picosoc_iomem_mux_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/picosoc_iomem_mux.sv
// iomem fabric: decodes a high-address window into one-hot slave slots and
// bounds every access with a timeout that answers with an error word.
module picosoc_iomem_mux #(
  parameter int unsigned NSLOTS     = 4,
  parameter logic [7:0]  BASE_HI    = 8'h03,
  parameter int unsigned SLOT_SHIFT = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  picosoc_iomem_mux_if.slave       bus,
  output logic [NSLOTS-1:0]        s_valid,
  input  logic [NSLOTS-1:0]        s_ready,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [32*NSLOTS-1:0]     s_rdata,
  output logic                     err_irq,
  output logic [31:0]              err_addr
);

  localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : CW'(0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_ready, w_ready_nxt;
  logic [31:0]         r_rdata, w_rdata_nxt;
  logic [NSLOTS-1:0]   r_s_valid, w_s_valid_nxt;
  logic [3:0]          r_s_wstrb, w_s_wstrb_nxt;
  logic [31:0]         r_s_addr, w_s_addr_nxt;
  logic [31:0]         r_s_wdata, w_s_wdata_nxt;
  logic                r_err_irq, w_err_irq_nxt;
  logic [31:0]         r_err_addr, w_err_addr_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;

  logic [2:0]          w_req_slot;
  logic [2:0]          w_act_slot;
  logic                w_mapped;
  logic [NSLOTS-1:0]   w_req_sel;
  logic                w_act_ready;
  logic [31:0]         w_act_rdata;

  assign w_req_slot = bus.iomem_addr[SLOT_SHIFT+2:SLOT_SHIFT];
  assign w_act_slot = r_s_addr[SLOT_SHIFT+2:SLOT_SHIFT];
  assign w_mapped   = (bus.iomem_addr[31:24] == BASE_HI) && (32'(w_req_slot) < NSLOTS);

  // Slot decode for new requests and AND-OR select of the active slot's response.
  always_comb begin
    w_req_sel   = {NSLOTS{1'b0}};
    w_act_ready = 1'b0;
    w_act_rdata = 32'd0;
    for (int k = 0; k < int'(NSLOTS); k++) begin
      w_req_sel[k] = (w_req_slot == 3'(k));
      w_act_ready  = w_act_ready | (s_ready[k] & (w_act_slot == 3'(k)));
      w_act_rdata  = w_act_rdata | (s_rdata[32*k +: 32] & {32{w_act_slot == 3'(k)}});
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-value logic for every registered output.
  always_comb begin
    w_state_nxt    = r_state;
    w_ready_nxt    = 1'b0;
    w_err_irq_nxt  = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_s_valid_nxt  = r_s_valid;
    w_s_wstrb_nxt  = r_s_wstrb;
    w_s_addr_nxt   = r_s_addr;
    w_s_wdata_nxt  = r_s_wdata;
    w_err_addr_nxt = r_err_addr;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.iomem_valid) begin
          w_s_addr_nxt  = bus.iomem_addr;
          w_s_wdata_nxt = bus.iomem_wdata;
          w_s_wstrb_nxt = bus.iomem_wstrb;
          if (w_mapped) begin
            w_s_valid_nxt = w_req_sel;
            w_cnt_nxt     = CW'(0);
            w_state_nxt   = ST_ACTIVE;
          end else begin
            w_rdata_nxt    = ERR_DATA;
            w_err_addr_nxt = bus.iomem_addr;
            w_err_irq_nxt  = 1'b1;
            w_ready_nxt    = 1'b1;
            w_state_nxt    = ST_RESP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // A master that drops valid mid-access is released silently.
        if (!bus.iomem_valid) begin
          w_s_valid_nxt = {NSLOTS{1'b0}};
          w_state_nxt   = ST_IDLE;
        end else if (w_act_ready) begin
          w_s_valid_nxt = {NSLOTS{1'b0}};
          w_rdata_nxt   = w_act_rdata;
          w_ready_nxt   = 1'b1;
          w_state_nxt   = ST_RESP;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_s_valid_nxt  = {NSLOTS{1'b0}};
          w_rdata_nxt    = ERR_DATA;
          w_err_addr_nxt = r_s_addr;
          w_err_irq_nxt  = 1'b1;
          w_ready_nxt    = 1'b1;
          w_state_nxt    = ST_RESP;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_s_valid_nxt = {NSLOTS{1'b0}};
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready    <= 1'b0;
      r_rdata    <= 32'd0;
      r_s_valid  <= {NSLOTS{1'b0}};
      r_s_wstrb  <= 4'd0;
      r_s_addr   <= 32'd0;
      r_s_wdata  <= 32'd0;
      r_err_irq  <= 1'b0;
      r_err_addr <= 32'd0;
      r_cnt      <= CW'(0);
    end else begin
      r_ready    <= w_ready_nxt;
      r_rdata    <= w_rdata_nxt;
      r_s_valid  <= w_s_valid_nxt;
      r_s_wstrb  <= w_s_wstrb_nxt;
      r_s_addr   <= w_s_addr_nxt;
      r_s_wdata  <= w_s_wdata_nxt;
      r_err_irq  <= w_err_irq_nxt;
      r_err_addr <= w_err_addr_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign bus.iomem_ready = r_ready;
  assign bus.iomem_rdata = r_rdata;
  assign s_valid         = r_s_valid;
  assign s_wstrb         = r_s_wstrb;
  assign s_addr          = r_s_addr;
  assign s_wdata         = r_s_wdata;
  assign err_irq         = r_err_irq;
  assign err_addr        = r_err_addr;

endmodule

// File: tb/tb_picosoc_iomem_mux.sv
// Directed bench for picosoc_iomem_mux (NSLOTS=4, TIMEOUT=8): reads, writes,
// decode errors, timeout, ready/timeout race, abort and mid-access reset.
module tb_picosoc_iomem_mux;
  logic         clk;
  logic         resetn;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [3:0]   s_wstrb;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic         err_irq;
  logic [31:0]  err_addr;

  int n_checks = 0;
  int n_errors = 0;

  picosoc_iomem_mux_if bus_if ();

  picosoc_iomem_mux #(
    .NSLOTS(4), .BASE_HI(8'h03), .SLOT_SHIFT(16), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus_if.slave),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .err_irq(err_irq), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = addr;
    bus_if.iomem_wstrb = wstrb;
    bus_if.iomem_wdata = wdata;
  endtask

  initial begin
    resetn = 1'b0;
    s_ready = 4'b0000;
    s_rdata = 128'd0;
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_addr  = 32'd0;
    bus_if.iomem_wstrb = 4'd0;
    bus_if.iomem_wdata = 32'd0;
    #2;
    check("rst_ready", {31'd0, bus_if.iomem_ready}, 32'd0);
    check("rst_svalid", {28'd0, s_valid}, 32'd0);
    check("rst_rdata", bus_if.iomem_rdata, 32'd0);
    check("rst_erraddr", err_addr, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Read slot 2, slave ready immediately.
    s_rdata[64 +: 32] = 32'h1234_5678;
    s_ready = 4'b0100;
    request(32'h0302_0010, 4'b0000, 32'd0);
    tick();
    check("rd_svalid", {28'd0, s_valid}, 32'h4);
    check("rd_saddr", s_addr, 32'h0302_0010);
    check("rd_ready0", {31'd0, bus_if.iomem_ready}, 32'd0);
    tick();
    check("rd_ready1", {31'd0, bus_if.iomem_ready}, 32'd1);
    check("rd_rdata", bus_if.iomem_rdata, 32'h1234_5678);
    check("rd_irq", {31'd0, err_irq}, 32'd0);
    bus_if.iomem_valid = 1'b0;
    tick();
    check("rd_ready_drop", {31'd0, bus_if.iomem_ready}, 32'd0);

    // Write slot 0, slave ready after 5 waiting cycles.
    s_ready = 4'b0000;
    s_rdata[0 +: 32] = 32'h0000_1111;
    request(32'h0300_0004, 4'b0011, 32'hA5A5_0000);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("wr_svalid", {28'd0, s_valid}, 32'h1);
      check("wr_swstrb", {28'd0, s_wstrb}, 32'h3);
      check("wr_swdata", s_wdata, 32'hA5A5_0000);
      check("wr_ready_wait", {31'd0, bus_if.iomem_ready}, 32'd0);
      if (i == 4) s_ready = 4'b0001;
      else s_ready = 4'b0000;
      tick();
    end
    check("wr_ready", {31'd0, bus_if.iomem_ready}, 32'd1);
    check("wr_svalid_drop", {28'd0, s_valid}, 32'h0);
    check("wr_irq", {31'd0, err_irq}, 32'd0);
    bus_if.iomem_valid = 1'b0;
    s_ready = 4'b0000;
    tick();
    check("wr_single_pulse", {31'd0, bus_if.iomem_ready}, 32'd0);

    // Unmapped: wrong high byte, then slot 5 beyond NSLOTS.
    for (int u = 0; u < 2; u++) begin
      logic [31:0] ua;
      ua = (u == 0) ? 32'h0400_0000 : 32'h0305_0000;
      request(ua, 4'b0000, 32'd0);
      check("um_svalid_acc", {28'd0, s_valid}, 32'h0);
      tick();
      check("um_ready", {31'd0, bus_if.iomem_ready}, 32'd1);
      check("um_rdata", bus_if.iomem_rdata, 32'hDEAD_BEEF);
      check("um_irq", {31'd0, err_irq}, 32'd1);
      check("um_erraddr", err_addr, ua);
      check("um_svalid", {28'd0, s_valid}, 32'h0);
      bus_if.iomem_valid = 1'b0;
      tick();
      check("um_irq_clear", {31'd0, err_irq}, 32'd0);
      check("um_ready_clear", {31'd0, bus_if.iomem_ready}, 32'd0);
    end

    // Timeout on slot 1; other slots ready but must be ignored.
    s_ready = 4'b1101;
    request(32'h0301_0020, 4'b0000, 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("to_svalid", {28'd0, s_valid}, 32'h2);
      check("to_ready_wait", {31'd0, bus_if.iomem_ready}, 32'd0);
      tick();
    end
    check("to_svalid_drop", {28'd0, s_valid}, 32'h0);
    check("to_ready", {31'd0, bus_if.iomem_ready}, 32'd1);
    check("to_rdata", bus_if.iomem_rdata, 32'hDEAD_BEEF);
    check("to_irq", {31'd0, err_irq}, 32'd1);
    check("to_erraddr", err_addr, 32'h0301_0020);
    bus_if.iomem_valid = 1'b0;
    s_ready = 4'b0000;
    tick();
    check("to_irq_clear", {31'd0, err_irq}, 32'd0);

    // Race: slot 1 ready in the final counting cycle wins over timeout.
    s_rdata[32 +: 32] = 32'hCAFE_F00D;
    request(32'h0301_0040, 4'b0000, 32'd0);
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("race_ready_wait", {31'd0, bus_if.iomem_ready}, 32'd0);
    s_ready = 4'b0010;
    tick();
    check("race_ready", {31'd0, bus_if.iomem_ready}, 32'd1);
    check("race_rdata", bus_if.iomem_rdata, 32'hCAFE_F00D);
    check("race_irq", {31'd0, err_irq}, 32'd0);
    bus_if.iomem_valid = 1'b0;
    s_ready = 4'b0000;
    tick();

    // Abort: master drops valid while ACTIVE.
    request(32'h0302_0000, 4'b0000, 32'd0);
    tick();
    tick();
    bus_if.iomem_valid = 1'b0;
    tick();
    check("ab_svalid", {28'd0, s_valid}, 32'h0);
    check("ab_ready", {31'd0, bus_if.iomem_ready}, 32'd0);
    check("ab_irq", {31'd0, err_irq}, 32'd0);
    tick();
    check("ab_ready_late", {31'd0, bus_if.iomem_ready}, 32'd0);

    // Reset in the middle of an ACTIVE access, then a normal access.
    request(32'h0303_0000, 4'b0000, 32'd0);
    tick();
    check("rs_svalid_pre", {28'd0, s_valid}, 32'h8);
    tick();
    resetn = 1'b0;
    bus_if.iomem_valid = 1'b0;
    #1;
    check("rs_svalid", {28'd0, s_valid}, 32'h0);
    check("rs_saddr", s_addr, 32'h0);
    tick();
    check("rs_ready", {31'd0, bus_if.iomem_ready}, 32'd0);
    resetn = 1'b1;
    tick();
    s_rdata[96 +: 32] = 32'h0BAD_F00D;
    s_ready = 4'b1000;
    request(32'h0303_0008, 4'b0000, 32'd0);
    tick();
    check("rs_next_svalid", {28'd0, s_valid}, 32'h8);
    tick();
    check("rs_next_ready", {31'd0, bus_if.iomem_ready}, 32'd1);
    check("rs_next_rdata", bus_if.iomem_rdata, 32'h0BAD_F00D);
    bus_if.iomem_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
